// File: rtl/bin_ceq_stim_gen.sv
// Stimulus source for the binary case-equality block: 8 directed corner vectors then LFSR vectors.
// Optional X/Z injection on random vectors is compiled in with BIN_CEQ_STIM_XZ_EN.
module bin_ceq_stim_gen #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE1_2015
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [15:0]  vec_index,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, DIRECTED, RANDOM, DONE} state_t;

  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
  localparam logic [31:0] TAPS     = 32'h8020_0003;

  state_t        state, state_n;
  logic          valid_n, busy_n, done_n, xfer;
  logic [127:0]  data_n;
  logic [15:0]   idx_n;
  logic [31:0]   lfsr, lfsr_n;

  // Fields packed as {a9, a4, a1, b9, b6, b2}.
  function automatic logic [30:0] dvec(input logic [2:0] i);
    logic [30:0] v;
    v = '0;
    case (i)
      3'd0: v = {9'h000, 4'h0, 1'b0, 9'h000, 6'h00, 2'h0};
      3'd1: v = {9'h1FF, 4'hF, 1'b1, 9'h1FF, 6'h3F, 2'h3};
      3'd2: v = {9'h0AA, 4'h5, 1'b1, 9'h0AA, 6'h05, 2'h1};
      3'd3: v = {9'h1FF, 4'h8, 1'b1, 9'h0FF, 6'h38, 2'h3};
      3'd4: v = {9'h100, 4'h7, 1'b0, 9'h000, 6'h07, 2'h2};
      3'd5: v = {9'h1FF, 4'hF, 1'b0, 9'h1FE, 6'h3F, 2'h0};
      3'd6: v = {9'h001, 4'h1, 1'b1, 9'h001, 6'h01, 2'h1};
      default: v = {9'h155, 4'hA, 1'b0, 9'h0AA, 6'h15, 2'h1};
    endcase
    return v;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? TAPS : 32'h0);
  endfunction

`ifdef BIN_CEQ_STIM_XZ_EN
  function automatic logic [30:0] inject(input logic [31:0] l);
    logic [30:0] r;
    r = l[30:0];
    for (int unsigned i = 0; i < 31; i++)
      if (l[31] ^ l[i % 31]) r[i] = l[0] ? 1'bz : 1'bx;
    return r;
  endfunction
`endif

  assign xfer = out_valid && out_ready;

  always_comb begin
    state_n = state;
    valid_n = out_valid;
    data_n  = out_data;
    idx_n   = vec_index;
    busy_n  = busy;
    done_n  = done;
    lfsr_n  = lfsr;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          if (NUM_VECTORS == 0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = DIRECTED;
            lfsr_n  = SEED_EFF;
            idx_n   = '0;
            valid_n = 1'b1;
            busy_n  = 1'b1;
            done_n  = 1'b0;
            data_n  = {97'b0, dvec(3'd0)};
          end
        end
      end
      DIRECTED, RANDOM: begin
        if (xfer) begin
          if (state == RANDOM) lfsr_n = lfsr_step(lfsr);
          if (vec_index == LAST_IDX) begin
            state_n = DONE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = vec_index + 16'd1;
            if (state == DIRECTED && vec_index != 16'd7) begin
              data_n = {97'b0, dvec(idx_n[2:0])};
            end else begin
              // First random vector uses the unstepped seed; later ones the stepped LFSR.
              state_n = RANDOM;
              data_n  = {97'b0, lfsr_n[30:0]};
`ifdef BIN_CEQ_STIM_XZ_EN
              if (idx_n[1:0] == 2'b11) data_n[30:0] = inject(lfsr_n);
`endif
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      vec_index <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      lfsr      <= 32'h1;
    end else begin
      state     <= state_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      vec_index <= idx_n;
      busy      <= busy_n;
      done      <= done_n;
      lfsr      <= lfsr_n;
    end
  end

endmodule
